// File: rtl/mbc_sbus_seq.sv
// rtl/mbc_sbus_seq.sv - SBUS memory-cycle sequencer: MEM START, ACKN/DATA VALID pulses, word stepping, NXM watchdog
module mbc_sbus_seq #(
    parameter int NXM_TIMEOUT = 256,
    parameter int CNT_W       = 9
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       mem_rq,
    input  logic       rd_rq,
    input  logic       wr_rq,
    input  logic [3:0] word_req,
    input  logic       sbus_ackn,
    input  logic       sbus_data_valid,
    output logic       mem_start,
    output logic       ackn_pulse,
    output logic       data_valid_pulse,
    output logic [1:0] word_sel,
    output logic       a_change_coming,
    output logic       core_busy,
    output logic       core_rd_in_prog,
    output logic       nxm_flag
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        RD_DATA = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NXM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             rw_q, rw_d;
    logic [3:0]       mask_q, mask_d;
    logic [1:0]       word_sel_q, word_sel_d;
    logic             mem_start_q, mem_start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ackn_d_q, dv_d_q;
    logic             ackn_pulse_q, dv_pulse_q;
    logic             nxm_d, a_change_d;
    logic             event_seen, expire;
    logic [3:0]       remaining;

    function automatic logic [1:0] low_bit(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Any bus event restarts the no-response watchdog and outranks expiry.
    assign event_seen = ackn_pulse_q | dv_pulse_q;
    assign expire     = (cnt_q == CNT_LAST) && !event_seen;
    assign remaining  = mask_q & ~(4'b0001 << word_sel_q);

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        mask_d      = mask_q;
        word_sel_d  = word_sel_q;
        mem_start_d = mem_start_q;
        nxm_d       = 1'b0;
        a_change_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_rq && (rd_rq || wr_rq) && (|word_req)) begin
                    rw_d        = rd_rq;
                    mask_d      = word_req;
                    word_sel_d  = low_bit(word_req);
                    mem_start_d = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                if (ackn_pulse_q) begin
                    mem_start_d = 1'b0;
                    if (rw_q) begin
                        state_d = RD_DATA;
                    end else begin
                        state_d = IDLE;
                        mask_d  = 4'b0000;
                    end
                end else if (expire) begin
                    nxm_d       = 1'b1;
                    mem_start_d = 1'b0;
                    state_d     = IDLE;
                    mask_d      = 4'b0000;
                end
            end
            RD_DATA: begin
                if (dv_pulse_q) begin
                    a_change_d = |(mask_q & (mask_q - 4'd1));
                    mask_d     = remaining;
                    if (|remaining) begin
                        word_sel_d = low_bit(remaining);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (expire) begin
                    nxm_d   = 1'b1;
                    state_d = IDLE;
                    mask_d  = 4'b0000;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_start_d = 1'b0;
                mask_d      = 4'b0000;
            end
        endcase
    end

    always_comb begin
        if ((state_q == IDLE) || (state_d != state_q) || event_seen) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            rw_q         <= 1'b0;
            mask_q       <= 4'b0000;
            word_sel_q   <= 2'd0;
            mem_start_q  <= 1'b0;
            cnt_q        <= '0;
            ackn_d_q     <= 1'b0;
            dv_d_q       <= 1'b0;
            ackn_pulse_q <= 1'b0;
            dv_pulse_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            mask_q       <= mask_d;
            word_sel_q   <= word_sel_d;
            mem_start_q  <= mem_start_d;
            cnt_q        <= cnt_d;
            ackn_d_q     <= sbus_ackn;
            dv_d_q       <= sbus_data_valid;
            ackn_pulse_q <= sbus_ackn & ~ackn_d_q;
            dv_pulse_q   <= sbus_data_valid & ~dv_d_q;
        end
    end

    assign mem_start        = mem_start_q;
    assign ackn_pulse       = ackn_pulse_q;
    assign data_valid_pulse = dv_pulse_q;
    assign word_sel         = word_sel_q;
    assign a_change_coming  = a_change_d;
    assign core_busy        = (state_q != IDLE);
    assign core_rd_in_prog  = (state_q == RD_DATA);
    assign nxm_flag         = nxm_d;

endmodule

// File: tb/tb_mbc_sbus_seq.sv
// tb/tb_mbc_sbus_seq.sv - directed self-checking bench for mbc_sbus_seq
module tb_mbc_sbus_seq;

    logic       clk;
    logic       RESET;
    logic       mem_rq;
    logic       rd_rq;
    logic       wr_rq;
    logic [3:0] word_req;
    logic       sbus_ackn;
    logic       sbus_data_valid;
    logic       mem_start;
    logic       ackn_pulse;
    logic       data_valid_pulse;
    logic [1:0] word_sel;
    logic       a_change_coming;
    logic       core_busy;
    logic       core_rd_in_prog;
    logic       nxm_flag;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;

    mbc_sbus_seq #(.NXM_TIMEOUT(8), .CNT_W(4)) dut (
        .clk             (clk),
        .RESET           (RESET),
        .mem_rq          (mem_rq),
        .rd_rq           (rd_rq),
        .wr_rq           (wr_rq),
        .word_req        (word_req),
        .sbus_ackn       (sbus_ackn),
        .sbus_data_valid (sbus_data_valid),
        .mem_start       (mem_start),
        .ackn_pulse      (ackn_pulse),
        .data_valid_pulse(data_valid_pulse),
        .word_sel        (word_sel),
        .a_change_coming (a_change_coming),
        .core_busy       (core_busy),
        .core_rd_in_prog (core_rd_in_prog),
        .nxm_flag        (nxm_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic rd, input logic wr, input logic [3:0] words);
        mem_rq   = 1'b1;
        rd_rq    = rd;
        wr_rq    = wr;
        word_req = words;
        tick();
        mem_rq   = 1'b0;
        rd_rq    = 1'b0;
        wr_rq    = 1'b0;
        word_req = 4'b0000;
    endtask

    task automatic all_zero(input string tag);
        chk(tag, {mem_start, ackn_pulse, data_valid_pulse, word_sel, a_change_coming,
                  core_busy, core_rd_in_prog, nxm_flag}, 8'h00);
    endtask

    // Raise DATA VALID for one edge, check the pulse cycle, then drop it.
    task automatic dv_beat(input string tag, input logic exp_change);
        sbus_data_valid = 1'b1;
        tick();
        chk({tag, "_dvp"}, {7'd0, data_valid_pulse}, 8'h01);
        chk({tag, "_acc"}, {7'd0, a_change_coming}, {7'd0, exp_change});
        sbus_data_valid = 1'b0;
        tick();
    endtask

    initial begin
        RESET = 1'b1; mem_rq = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; word_req = 4'b0000;
        sbus_ackn = 1'b0; sbus_data_valid = 1'b0;
        #12;
        all_zero("reset_outputs");
        RESET = 1'b0;
        tick();
        all_zero("idle_after_reset");

        // 1: read 1011 -> words 0,1,3
        request(1'b1, 1'b0, 4'b1011);
        chk("t1_mem_start", {7'd0, mem_start}, 8'h01);
        chk("t1_wsel0", {6'd0, word_sel}, 8'h00);
        chk("t1_busy", {7'd0, core_busy}, 8'h01);
        sbus_ackn = 1'b1;
        tick();
        chk("t1_ackn_pulse", {7'd0, ackn_pulse}, 8'h01);
        chk("t1_rip_start", {7'd0, core_rd_in_prog}, 8'h00);
        sbus_ackn = 1'b0;
        tick();
        chk("t1_rip", {7'd0, core_rd_in_prog}, 8'h01);
        chk("t1_mem_start_off", {7'd0, mem_start}, 8'h00);
        dv_beat("t1_w0", 1'b1);
        chk("t1_wsel1", {6'd0, word_sel}, 8'h01);
        dv_beat("t1_w1", 1'b1);
        chk("t1_wsel3", {6'd0, word_sel}, 8'h03);
        sbus_data_valid = 1'b1;
        tick();
        chk("t1_last_acc", {7'd0, a_change_coming}, 8'h00);
        chk("t1_last_busy", {7'd0, core_busy}, 8'h01);
        tick();
        chk("t1_done_busy", {7'd0, core_busy}, 8'h00);
        chk("t1_done_dvp_held", {7'd0, data_valid_pulse}, 8'h00);
        sbus_data_valid = 1'b0;
        tick();

        // 2: write 0100, ACKN held 6 cycles
        request(1'b0, 1'b1, 4'b0100);
        chk("t2_wsel2", {6'd0, word_sel}, 8'h02);
        sbus_ackn = 1'b1;
        pulses = 0;
        tick();
        pulses += int'(ackn_pulse);
        chk("t2_mem_start_pulse", {7'd0, mem_start}, 8'h01);
        tick();
        chk("t2_mem_start_after", {7'd0, mem_start}, 8'h00);
        chk("t2_idle", {7'd0, core_busy}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            pulses += int'(ackn_pulse);
            tick();
        end
        chk("t2_one_pulse", 8'(pulses), 8'h01);
        sbus_ackn = 1'b0;
        tick();

        // 3: read with no ACKN, timeout 8
        request(1'b1, 1'b0, 4'b0001);
        chk("t3_nxm_c0", {7'd0, nxm_flag}, 8'h00);
        for (int i = 1; i < 7; i++) begin
            tick();
            chk("t3_nxm_early", {7'd0, nxm_flag}, 8'h00);
        end
        tick();
        chk("t3_nxm_fire", {7'd0, nxm_flag}, 8'h01);
        tick();
        chk("t3_nxm_single", {7'd0, nxm_flag}, 8'h00);
        chk("t3_mem_start", {7'd0, mem_start}, 8'h00);
        chk("t3_busy", {7'd0, core_busy}, 8'h00);

        // 4: ACKN pulse lands on the expiry cycle
        request(1'b1, 1'b0, 4'b0001);
        repeat (6) tick();
        sbus_ackn = 1'b1;
        tick();
        chk("t4_ackn_pulse", {7'd0, ackn_pulse}, 8'h01);
        chk("t4_no_nxm", {7'd0, nxm_flag}, 8'h00);
        tick();
        sbus_ackn = 1'b0;
        chk("t4_rd_data", {7'd0, core_rd_in_prog}, 8'h01);
        repeat (6) tick();
        chk("t4_restart_quiet", {7'd0, nxm_flag}, 8'h00);
        tick();
        chk("t4_restart_fire", {7'd0, nxm_flag}, 8'h01);
        tick();
        chk("t4_idle", {7'd0, core_busy}, 8'h00);

        // 5: reset mid-read of 1111 after word 0
        request(1'b1, 1'b0, 4'b1111);
        sbus_ackn = 1'b1;
        tick();
        sbus_ackn = 1'b0;
        tick();
        dv_beat("t5_w0", 1'b1);
        chk("t5_wsel1", {6'd0, word_sel}, 8'h01);
        RESET = 1'b1;
        #1;
        all_zero("t5_async_reset");
        tick();
        RESET = 1'b0;
        tick();
        request(1'b1, 1'b0, 4'b1111);
        chk("t5_restart_wsel0", {6'd0, word_sel}, 8'h00);

        // 6: mem_rq ignored during RD_DATA and when unqualified in IDLE
        sbus_ackn = 1'b1;
        tick();
        sbus_ackn = 1'b0;
        tick();
        request(1'b1, 1'b0, 4'b0001);
        chk("t6_rip_kept", {7'd0, core_rd_in_prog}, 8'h01);
        chk("t6_wsel_kept", {6'd0, word_sel}, 8'h00);
        dv_beat("t6_mask_kept", 1'b1);
        chk("t6_wsel_next", {6'd0, word_sel}, 8'h01);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        request(1'b1, 1'b0, 4'b0000);
        chk("t6_zero_words", {7'd0, core_busy}, 8'h00);
        request(1'b0, 1'b0, 4'b1111);
        chk("t6_unqualified", {7'd0, core_busy}, 8'h00);
        chk("t6_no_start", {7'd0, mem_start}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
